alu_mul_sequencer: RTL and testbench

- Multi-cycle unsigned shift-and-add multiplier that owns and sequences the shared 16-bit ALU during a MUL operation.
- Issues one ALU ADD per multiplier bit and accumulates the result.
- Returns the low 16 bits of the product with a start/done handshake.
- Sits beside the datapath ALU. The top-level mux hands ALU inputs to this block while busy is high.

---
 rtl/slc3_alu_pkg.sv | 20 ++
 rtl/alu_mul_sequencer.sv | 111 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/slc3_alu_pkg.sv
// Shared ALU definitions for the SLC-3 datapath and the blocks that borrow its ALU.
// Holds the ALU op encoding, the multiply sequencer states and the machine word width.
package slc3_alu_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_PASS = 2'b11
   } aluk_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared ALU for one ADD per multiplier bit.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer
   import slc3_alu_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [1:0]       alu_aluk,
   output logic [WIDTH-1:0] alu_one,
   output logic [WIDTH-1:0] alu_two,
   input  logic [WIDTH-1:0] alu_q
);

   mul_state_t       state_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] product_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] mplier_d;
   logic             lastIter;

   // The accumulator only takes the ALU sum when the current multiplier bit is set.
   always_comb begin
      acc_d    = mplier_q[0] ? alu_q : acc_q;
      mplier_d = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
      lastIter = (mplier_d == '0);
`else
      lastIter = (cnt_q == CNT_W'(WIDTH - 1));
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q  <= op_a;
                  mplier_q <= op_b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + 1'b1;
               // The final add lands in the product in the same edge that leaves RUN.
               if (lastIter) begin
                  product_q <= acc_d;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outside RUN the ALU is left in a harmless PASS of zero.
   always_comb begin
      if (state_q == RUN) begin
         alu_aluk = ALU_ADD;
         alu_one  = acc_q;
         alu_two  = mcand_q;
      end else begin
         alu_aluk = ALU_PASS;
         alu_one  = '0;
         alu_two  = '0;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural stand-in for the shared ALU.
// Expected latency follows MUL_EARLY_EXIT_EN when the bench is built with it defined.
module tb_alu_mul_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [1:0]  alu_aluk;
   logic [15:0] alu_one;
   logic [15:0] alu_two;
   logic [15:0] alu_q;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acceptCyc = 0;

   alu_mul_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .alu_aluk (alu_aluk),
      .alu_one  (alu_one),
      .alu_two  (alu_two),
      .alu_q    (alu_q)
   );

   // Datapath ALU model: ADD, AND, NOT, PASS.
   always_comb begin
      case (alu_aluk)
         2'b00:   alu_q = alu_one + alu_two;
         2'b01:   alu_q = alu_one & alu_two;
         2'b10:   alu_q = ~alu_one;
         default: alu_q = alu_one;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [31:0] refProduct(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] full;
      full = 32'(a) * 32'(b);
      return {16'h0, full[15:0]};
   endfunction

   // Number of RUN cycles between acceptance and the done strobe.
   function automatic int refLat(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
      int h;
      h = 0;
      for (int i = 0; i < 16; i++) if (b[i]) h = i + 1;
      return (h == 0) ? 1 : h;
`else
      return 16;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one start pulse from IDLE; returns at the negedge after the accepting edge.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      op_a      = 16'($urandom);
      op_b      = 16'($urandom);
      acceptCyc = cyc;
      checkOutput("busy_after_start", {31'h0, busy}, 32'd1);
   endtask

   task automatic waitDone(input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         checkOutput("aluk_run", {30'h0, alu_aluk}, 32'd0);
         @(negedge clk);
         n++;
      end
      checkOutput("done_seen", {31'h0, done}, 32'd1);
      checkOutput("latency", 32'(cyc - acceptCyc), 32'(refLat(b)));
      checkOutput("product", {16'h0, product}, refProduct(a, b));
      checkOutput("aluk_done", {30'h0, alu_aluk}, 32'd3);
      @(negedge clk);
      checkOutput("done_single", {31'h0, done}, 32'd0);
      checkOutput("busy_fall", {31'h0, busy}, 32'd0);
      checkOutput("product_hold", {16'h0, product}, refProduct(a, b));
   endtask

   initial begin
      int dones;
      int prevCyc;
      logic [15:0] ra;
      logic [15:0] rb;

      reset = 1'b1;
      start = 1'b0;
      op_a  = 16'h0;
      op_b  = 16'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_busy", {31'h0, busy}, 32'd0);
      checkOutput("reset_done", {31'h0, done}, 32'd0);
      checkOutput("reset_product", {16'h0, product}, 32'd0);
      checkOutput("reset_aluk", {30'h0, alu_aluk}, 32'd3);
      checkOutput("reset_one", {16'h0, alu_one}, 32'd0);
      checkOutput("reset_two", {16'h0, alu_two}, 32'd0);

      applyStimulus(16'd3, 16'd5);
      waitDone(16'd3, 16'd5);
      applyStimulus(16'hFFFF, 16'hFFFF);
      waitDone(16'hFFFF, 16'hFFFF);
      applyStimulus(16'h1234, 16'h0000);
      waitDone(16'h1234, 16'h0000);
      applyStimulus(16'hBEEF, 16'h0001);
      waitDone(16'hBEEF, 16'h0001);

      // A start pulse while the multiply is still running must be dropped.
      applyStimulus(16'd7, 16'd9);
      repeat (2) @(negedge clk);
      op_a  = 16'd2;
      op_b  = 16'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(16'd7, 16'd9);
      applyStimulus(16'd2, 16'd2);
      waitDone(16'd2, 16'd2);

      // Reset mid-run abandons the operation silently.
      applyStimulus(16'h00FF, 16'h0101);
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midreset_busy", {31'h0, busy}, 32'd0);
      checkOutput("midreset_done", {31'h0, done}, 32'd0);
      checkOutput("midreset_product", {16'h0, product}, 32'd0);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      checkOutput("no_done_after_reset", 32'(dones), 32'd0);
      applyStimulus(16'h00FF, 16'h0101);
      waitDone(16'h00FF, 16'h0101);

      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = (i < 4) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         applyStimulus(ra, rb);
         waitDone(ra, rb);
      end

      // Start held high: one operation every RUN length plus DONE and IDLE cycles.
      @(negedge clk);
      op_a  = 16'h0010;
      op_b  = 16'h0010;
      start = 1'b1;
      @(negedge clk);
      prevCyc = cyc;
      for (int k = 0; k < 3; k++) begin
         int n;
         n = 0;
         while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
         end
         checkOutput("b2b_done_seen", {31'h0, done}, 32'd1);
         checkOutput("b2b_period", 32'(cyc - prevCyc),
                     32'((k == 0) ? refLat(16'h0010) : refLat(16'h0010) + 2));
         checkOutput("b2b_product", {16'h0, product}, 32'h0100);
         prevCyc = cyc;
         if (k == 2) start = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
      checkOutput("b2b_idle", {31'h0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
